// File: rtl/cache_control_nway.sv
// N-way set-associative write-back/write-allocate cache controller FSM.
// Sequences hit/miss handling, victim writeback and line fill; keeps saturating statistics.
module cache_control_nway #(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned WAY_W = $clog2(WAYS),
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             hit,
    input  logic [WAY_W-1:0] hit_way,
    input  logic [WAY_W-1:0] lru_way,
    input  logic             victim_valid,
    input  logic             victim_dirty,
    input  logic             pmem_resp,
    output logic             mem_resp,
    output logic [WAY_W-1:0] sel_way,
    output logic [WAYS-1:0]  data_write,
    output logic [WAYS-1:0]  valid_write,
    output logic [WAYS-1:0]  dirty_write,
    output logic             dirty_val,
    output logic             fill_sel,
    output logic             lru_update,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             pmem_addr_sel,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWriteback,
        StFill,
        StRespond
    } state_e;

    localparam logic [WAYS-1:0] OneHotBase = {{(WAYS-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic [CNT_W-1:0]   hit_count_q, hit_count_d;
    logic [CNT_W-1:0]   miss_count_q, miss_count_d;
    logic [CNT_W-1:0]   wb_count_q, wb_count_d;

    logic req;
    logic hit_inc, miss_inc, wb_inc;

    assign req = mem_read | mem_write;

    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        wb_inc        = 1'b0;
        mem_resp      = 1'b0;
        sel_way       = '0;
        data_write    = '0;
        valid_write   = '0;
        dirty_write   = '0;
        dirty_val     = 1'b0;
        fill_sel      = 1'b0;
        lru_update    = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) state_d = StLookup;
            end
            StLookup: begin
                if (!req) begin
                    state_d = StIdle;
                end else if (hit) begin
                    mem_resp   = 1'b1;
                    sel_way    = hit_way;
                    lru_update = 1'b1;
                    hit_inc    = 1'b1;
                    // mem_write wins when both request lines are raised
                    if (mem_write) begin
                        data_write  = OneHotBase << hit_way;
                        dirty_write = OneHotBase << hit_way;
                        dirty_val   = 1'b1;
                    end
                    state_d = StIdle;
                end else begin
                    victim_d = lru_way;
                    miss_inc = 1'b1;
                    state_d  = (victim_valid && victim_dirty) ? StWriteback : StFill;
                end
            end
            StWriteback: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                sel_way       = victim_q;
                if (pmem_resp) begin
                    dirty_write = OneHotBase << victim_q;
                    wb_inc      = 1'b1;
                    state_d     = StFill;
                end
            end
            StFill: begin
                pmem_read = 1'b1;
                sel_way   = victim_q;
                if (pmem_resp) begin
                    data_write  = OneHotBase << victim_q;
                    valid_write = OneHotBase << victim_q;
                    dirty_write = OneHotBase << victim_q;
                    fill_sel    = 1'b1;
                    state_d     = StRespond;
                end
            end
            StRespond: begin
                mem_resp   = 1'b1;
                sel_way    = victim_q;
                lru_update = 1'b1;
                if (mem_write) begin
                    data_write  = OneHotBase << victim_q;
                    dirty_write = OneHotBase << victim_q;
                    dirty_val   = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        hit_count_d  = (hit_inc && hit_count_q != '1) ? hit_count_q + CNT_W'(1) : hit_count_q;
        miss_count_d = (miss_inc && miss_count_q != '1) ? miss_count_q + CNT_W'(1) : miss_count_q;
        wb_count_d   = (wb_inc && wb_count_q != '1) ? wb_count_q + CNT_W'(1) : wb_count_q;

        // Reset silences every control output, even mid-transaction
        if (rst) begin
            mem_resp      = 1'b0;
            sel_way       = '0;
            data_write    = '0;
            valid_write   = '0;
            dirty_write   = '0;
            dirty_val     = 1'b0;
            fill_sel      = 1'b0;
            lru_update    = 1'b0;
            pmem_read     = 1'b0;
            pmem_write    = 1'b0;
            pmem_addr_sel = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            victim_q     <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;

endmodule

// File: tb/tb_cache_control_nway.sv
// Randomized transaction-level bench for cache_control_nway; expected per-cycle outputs are
// derived from each transaction's kind and latencies, counters from plain event tallies.
module tb_cache_control_nway;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_read = 1'b0, mem_write = 1'b0, hit = 1'b0;
    logic [1:0] hit_way = '0, lru_way = '0;
    logic       victim_valid = 1'b0, victim_dirty = 1'b0, pmem_resp = 1'b0;

    logic        mem_resp, dirty_val, fill_sel, lru_update, pmem_read, pmem_write, pmem_addr_sel;
    logic [1:0]  sel_way;
    logic [3:0]  data_write, valid_write, dirty_write;
    logic [15:0] hit_count, miss_count, wb_count;

    logic        s_mem_resp, s_dirty_val, s_fill_sel, s_lru_update;
    logic        s_pmem_read, s_pmem_write, s_pmem_addr_sel;
    logic [1:0]  s_sel_way;
    logic [3:0]  s_data_write, s_valid_write, s_dirty_write;
    logic [1:0]  s_hit_count, s_miss_count, s_wb_count;

    always #5 clk = ~clk;

    cache_control_nway #(.WAYS(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .hit(hit),
        .hit_way(hit_way), .lru_way(lru_way), .victim_valid(victim_valid),
        .victim_dirty(victim_dirty), .pmem_resp(pmem_resp), .mem_resp(mem_resp),
        .sel_way(sel_way), .data_write(data_write), .valid_write(valid_write),
        .dirty_write(dirty_write), .dirty_val(dirty_val), .fill_sel(fill_sel),
        .lru_update(lru_update), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_addr_sel(pmem_addr_sel), .hit_count(hit_count), .miss_count(miss_count),
        .wb_count(wb_count)
    );

    cache_control_nway #(.WAYS(4), .CNT_W(2)) u_small (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .hit(hit),
        .hit_way(hit_way), .lru_way(lru_way), .victim_valid(victim_valid),
        .victim_dirty(victim_dirty), .pmem_resp(pmem_resp), .mem_resp(s_mem_resp),
        .sel_way(s_sel_way), .data_write(s_data_write), .valid_write(s_valid_write),
        .dirty_write(s_dirty_write), .dirty_val(s_dirty_val), .fill_sel(s_fill_sel),
        .lru_update(s_lru_update), .pmem_read(s_pmem_read), .pmem_write(s_pmem_write),
        .pmem_addr_sel(s_pmem_addr_sel), .hit_count(s_hit_count), .miss_count(s_miss_count),
        .wb_count(s_wb_count)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Expected outputs for the current cycle
    logic       e_mem_resp, e_dval, e_fill, e_lru, e_pr, e_pw, e_pas;
    logic [1:0] e_sel;
    logic [3:0] e_dw, e_vw, e_dwr;

    // Event tallies; counters are these saturated at 2**CNT_W - 1
    int n_hit = 0, n_miss = 0, n_wb = 0;
    bit pend_h, pend_m, pend_w, pend_clr;

    // Snapshots of outputs at notable cycles for literal checks
    logic [1:0] cap_sel;
    logic [3:0] cap_dw, cap_dwr, cap_fdw, cap_fvw, cap_wbdwr;
    logic       cap_dval, cap_lru, cap_ffill, cap_pas, cap_wbdval, cap_rst_pr;

    function automatic logic [3:0] oh(input logic [1:0] w);
        logic [3:0] b;
        b = 4'b0001;
        return b << w;
    endfunction

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("mem_resp", 32'(mem_resp), 32'(e_mem_resp));
            chk("sel_way", 32'(sel_way), 32'(e_sel));
            chk("data_write", 32'(data_write), 32'(e_dw));
            chk("valid_write", 32'(valid_write), 32'(e_vw));
            chk("dirty_write", 32'(dirty_write), 32'(e_dwr));
            chk("dirty_val", 32'(dirty_val), 32'(e_dval));
            chk("fill_sel", 32'(fill_sel), 32'(e_fill));
            chk("lru_update", 32'(lru_update), 32'(e_lru));
            chk("pmem_read", 32'(pmem_read), 32'(e_pr));
            chk("pmem_write", 32'(pmem_write), 32'(e_pw));
            chk("pmem_addr_sel", 32'(pmem_addr_sel), 32'(e_pas));
            chk("hit_count", 32'(hit_count), 32'(sat(n_hit, 16)));
            chk("miss_count", 32'(miss_count), 32'(sat(n_miss, 16)));
            chk("wb_count", 32'(wb_count), 32'(sat(n_wb, 16)));
            chk("small_hit_count", 32'(s_hit_count), 32'(sat(n_hit, 2)));
            chk("small_miss_count", 32'(s_miss_count), 32'(sat(n_miss, 2)));
            chk("small_wb_count", 32'(s_wb_count), 32'(sat(n_wb, 2)));
        end
        if (mem_resp) begin
            cap_sel  = sel_way;
            cap_dw   = data_write;
            cap_dwr  = dirty_write;
            cap_dval = dirty_val;
            cap_lru  = lru_update;
        end
        if (fill_sel) begin
            cap_fdw   = data_write;
            cap_fvw   = valid_write;
            cap_ffill = fill_sel;
        end
        if (pmem_write) cap_pas = pmem_addr_sel;
        if (pmem_write && pmem_resp) begin
            cap_wbdwr  = dirty_write;
            cap_wbdval = dirty_val;
        end
        if (rst) cap_rst_pr = pmem_read;
    end

    // Advance one cycle, retire last cycle's events, and set don't-care inputs to noise
    task automatic step();
        @(posedge clk);
        #1;
        if (pend_clr) begin
            n_hit = 0; n_miss = 0; n_wb = 0;
        end else begin
            n_hit += int'(pend_h); n_miss += int'(pend_m); n_wb += int'(pend_w);
        end
        {pend_h, pend_m, pend_w, pend_clr} = '0;
        rst = 1'b0;
        mem_read = 1'b0;
        mem_write = 1'b0;
        hit = 1'($urandom_range(0, 1));
        hit_way = 2'($urandom_range(0, 3));
        lru_way = 2'($urandom_range(0, 3));
        victim_valid = 1'($urandom_range(0, 1));
        victim_dirty = 1'($urandom_range(0, 1));
        pmem_resp = 1'($urandom_range(0, 1));
        {e_mem_resp, e_dval, e_fill, e_lru, e_pr, e_pw, e_pas} = '0;
        e_sel = '0; e_dw = '0; e_vw = '0; e_dwr = '0;
    endtask

    task automatic drive_req(input bit wr);
        if (wr) begin
            mem_write = 1'b1;
            mem_read = 1'($urandom_range(0, 1));
        end else begin
            mem_read = 1'b1;
        end
    endtask

    task automatic respond(input bit wr, input logic [1:0] way);
        e_mem_resp = 1'b1;
        e_sel = way;
        e_lru = 1'b1;
        if (wr) begin
            e_dw = oh(way);
            e_dwr = oh(way);
            e_dval = 1'b1;
        end
    endtask

    // One CPU transaction starting in idle; rst_fill >= 0 asserts reset in that fill cycle
    task automatic do_txn(input bit wr, input bit hitv, input logic [1:0] hw,
                          input logic [1:0] lru, input bit vv, input bit vd,
                          input int wb_lat, input int fill_lat, input int rst_fill);
        logic [1:0] vic;
        step(); drive_req(wr);
        step(); drive_req(wr);
        hit = hitv; hit_way = hw; lru_way = lru; victim_valid = vv; victim_dirty = vd;
        if (hitv) begin
            respond(wr, hw);
            pend_h = 1'b1;
            return;
        end
        pend_m = 1'b1;
        vic = lru;
        if (vv && vd) begin
            for (int i = 0; i <= wb_lat; i++) begin
                step(); drive_req(wr);
                pmem_resp = (i == wb_lat);
                e_pw = 1'b1; e_pas = 1'b1; e_sel = vic;
                if (pmem_resp) begin
                    e_dwr = oh(vic);
                    pend_w = 1'b1;
                end
            end
        end
        for (int i = 0; i <= fill_lat; i++) begin
            step(); drive_req(wr);
            if (i == rst_fill) begin
                rst = 1'b1;
                pend_clr = 1'b1;
                return;
            end
            pmem_resp = (i == fill_lat);
            e_pr = 1'b1; e_sel = vic;
            if (pmem_resp) begin
                e_dw = oh(vic); e_vw = oh(vic); e_dwr = oh(vic); e_fill = 1'b1;
            end
        end
        step(); drive_req(wr);
        respond(wr, vic);
    endtask

    task automatic drop_req();
        step(); drive_req(1'($urandom_range(0, 1)));
        step();
    endtask

    initial begin
        rst = 1'b1;
        pend_clr = 1'b1;
        step(); rst = 1'b1; pend_clr = 1'b1;
        chk_en = 1'b1;
        step(); rst = 1'b1; pend_clr = 1'b1;
        step();

        // Read hit in way 2
        do_txn(1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 0, 0, -1);
        step();
        chk("t1_hit_count", 32'(hit_count), 32'd1);
        chk("t1_sel_way", 32'(cap_sel), 32'd2);
        chk("t1_data_write", 32'(cap_dw), 32'd0);
        chk("t1_lru_update", 32'(cap_lru), 32'd1);

        // Write hit in way 3
        do_txn(1'b1, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 0, 0, -1);
        step();
        chk("t2_data_write", 32'(cap_dw), 32'h8);
        chk("t2_dirty_write", 32'(cap_dwr), 32'h8);
        chk("t2_dirty_val", 32'(cap_dval), 32'd1);
        chk("t2_hit_count", 32'(hit_count), 32'd2);

        // Clean read miss, victim 1, fill response on the 5th fill cycle
        do_txn(1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 0, 4, -1);
        step();
        chk("t3_fill_data_write", 32'(cap_fdw), 32'h2);
        chk("t3_fill_valid_write", 32'(cap_fvw), 32'h2);
        chk("t3_fill_sel", 32'(cap_ffill), 32'd1);
        chk("t3_miss_count", 32'(miss_count), 32'd1);

        // Dirty write miss, victim 0
        do_txn(1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 1'b1, 3, 2, -1);
        step();
        chk("t4_pmem_addr_sel", 32'(cap_pas), 32'd1);
        chk("t4_wb_dirty_write", 32'(cap_wbdwr), 32'h1);
        chk("t4_wb_dirty_val", 32'(cap_wbdval), 32'd0);
        chk("t4_resp_data_write", 32'(cap_dw), 32'h1);
        chk("t4_resp_dirty_val", 32'(cap_dval), 32'd1);
        chk("t4_wb_count", 32'(wb_count), 32'd1);

        // lru_way wanders every fill cycle; the latched victim 3 must still be written
        do_txn(1'b0, 1'b0, 2'd0, 2'd3, 1'b0, 1'b1, 0, 6, -1);
        step();
        chk("t5_fill_data_write", 32'(cap_fdw), 32'h8);

        // Reset in the middle of a fill
        do_txn(1'b0, 1'b0, 2'd0, 2'd2, 1'b1, 1'b1, 1, 3, 1);
        step();
        chk("t6_rst_pmem_read", 32'(cap_rst_pr), 32'd0);
        chk("t6_hit_count", 32'(hit_count), 32'd0);
        chk("t6_miss_count", 32'(miss_count), 32'd0);
        chk("t6_wb_count", 32'(wb_count), 32'd0);
        for (int i = 0; i < 5; i++)
            do_txn(1'b0, 1'b1, 2'($urandom_range(0, 3)), 2'd0, 1'b0, 1'b0, 0, 0, -1);
        step();
        chk("t6_small_hit_sat", 32'(s_hit_count), 32'd3);
        chk("t6_hit_count_5", 32'(hit_count), 32'd5);

        for (int n = 0; n < 400; n++) begin
            int kind;
            kind = int'($urandom_range(0, 19));
            if (kind < 8) begin
                do_txn(1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 0, 0, -1);
            end else if (kind < 16) begin
                do_txn(1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
                       int'($urandom_range(0, 5)), -1);
            end else if (kind < 18) begin
                drop_req();
            end else if (kind < 19) begin
                do_txn(1'($urandom_range(0, 1)), 1'b0, 2'd0, 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), 3, int'($urandom_range(0, 3)));
            end else begin
                step();
            end
        end
        step();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
